// File: rtl/logic_op_scheduler_if.sv
// Request/response bundle between the two ALU requesters and the shared bitwise unit.
// The scheduler takes the slave side; the requesters (or a bench) take the master side.
interface logic_op_scheduler_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;

  logic             req1_valid;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid,
    input  rsp0_ready,
    output rsp1_valid,
    input  rsp1_ready,
    output rsp_data, rsp_zero, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid,
    output rsp0_ready,
    input  rsp1_valid,
    output rsp1_ready,
    input  rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one bitwise logic unit (OR/NOR/AND/XOR) between two requesters.
// One operation in flight; the registered result is held until its owner takes it.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, round-robin on `last`
// EXEC  | operands captured; result computed and registered at the end of this cycle
// RESP  | result held on rsp_data/rsp_zero until the owner's rsp_ready
module logic_op_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_op_scheduler_if.slave  bus
);

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_NOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_q;
  logic             owner_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_zero_q;
  logic             rsp_valid_q;
  logic             grant0;
  logic             grant1;
  logic             accept_open;
  logic             accept;
  logic             take;

  // With both requesters pending, the one not served last wins.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
  end

  // Ready is also gated by rst since the async reset lands the state in IDLE.
  assign accept_open    = (state_q == IDLE) && !rst;
  assign bus.req0_ready = accept_open && grant0;
  assign bus.req1_ready = accept_open && grant1;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign take           = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    result = a_q ^ b_q;
    case (op_q)
      OP_OR:   result = a_q | b_q;
      OP_NOR:  result = ~(a_q | b_q);
      OP_AND:  result = a_q & b_q;
      default: result = a_q ^ b_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else if (state_q == IDLE && accept) begin
      op_q    <= bus.req1_ready ? bus.req1_op : bus.req0_op;
      a_q     <= bus.req1_ready ? bus.req1_a  : bus.req0_a;
      b_q     <= bus.req1_ready ? bus.req1_b  : bus.req0_b;
      owner_q <= bus.req1_ready;
      last_q  <= bus.req1_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        EXEC: begin
          rsp_data_q  <= result;
          rsp_zero_q  <= (result == '0);
          rsp_valid_q <= 1'b1;
        end
        RESP: if (take) rsp_valid_q <= 1'b0;
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.rsp0_valid = rsp_valid_q && !owner_q;
  assign bus.rsp1_valid = rsp_valid_q && owner_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = (state_q == EXEC) || (state_q == RESP);

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model of the scheduler.
module tb_logic_op_scheduler;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;

  logic_op_scheduler_if #(.WIDTH(WIDTH)) bus ();
  logic_op_scheduler #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'd0:    return a | b;
      2'd1:    return ~(a | b);
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Transaction-level model: in flight or not, who owns it, and how long since acceptance.
  int               m_age = -1;     // -1 idle, 0 just accepted, >=1 response outstanding
  logic             m_last = 1'b1;
  logic             m_owner = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_zero = 1'b0;
  logic             e_r0, e_r1, e_busy, e_v0, e_v1;
  logic [WIDTH-1:0] exp_q0[$];
  logic [WIDTH-1:0] exp_q1[$];
  logic [WIDTH-1:0] popped;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs",
            64'({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid,
                 bus.rsp_data, bus.rsp_zero}), 64'd0);
      m_age = -1; m_last = 1'b1; m_data = '0; m_zero = 1'b0;
      exp_q0.delete(); exp_q1.delete();
    end else begin
      e_r0   = (m_age < 0) && bus.req0_valid && (!bus.req1_valid || m_last);
      e_r1   = (m_age < 0) && bus.req1_valid && (!bus.req0_valid || !m_last);
      e_busy = (m_age >= 0);
      e_v0   = (m_age >= 1) && !m_owner;
      e_v1   = (m_age >= 1) && m_owner;
      check("cycle_outputs",
            64'({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid,
                 bus.rsp_data, bus.rsp_zero}),
            64'({e_r0, e_r1, e_busy, e_v0, e_v1, m_data, m_zero}));
      if (bus.rsp0_valid || bus.rsp1_valid)
        check("zero_flag", 64'(bus.rsp_zero), 64'(bus.rsp_data == '0));
      if (m_age < 0) begin
        if (e_r0 || e_r1) begin
          m_owner  = e_r1;
          m_last   = e_r1;
          m_result = e_r1 ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                          : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
          if (e_r1) exp_q1.push_back(m_result); else exp_q0.push_back(m_result);
          m_age = 0;
        end
      end else if (m_age == 0) begin
        m_data = m_result;
        m_zero = (m_result == '0);
        m_age  = 1;
      end else begin
        m_age++;
        if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
          popped = m_owner ? exp_q1.pop_front() : exp_q0.pop_front();
          check(m_owner ? "rsp1_order" : "rsp0_order", 64'(bus.rsp_data), 64'(popped));
          m_age = -1;
        end
      end
    end
  end

  task automatic drive_req(input int r, input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic wait_ready(input int r, output int waited);
    bit ok = 0;
    waited = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if ((r == 0) ? bus.req0_ready : bus.req1_ready) ok = 1;
      else waited++;
    end
    if (!ok) check("wait_ready_timeout", 64'd0, 64'd1);
  endtask

  // Issue one op with rsp_ready high; check 2-cycle latency and the literal result.
  task automatic run_op(input int r, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                        input logic expz, output int waited);
    @(posedge clk); #1;
    drive_req(r, op, a, b);
    wait_ready(r, waited);
    @(posedge clk); #1;
    if (r == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    @(negedge clk);
    check("exec_busy_novalid", 64'({bus.busy, bus.rsp0_valid, bus.rsp1_valid}), 64'(3'b100));
    @(negedge clk);
    check("rsp_valid_owner", 64'({bus.rsp0_valid, bus.rsp1_valid}),
          (r == 0) ? 64'(2'b10) : 64'(2'b01));
    check("rsp_data", 64'(bus.rsp_data), 64'(exp));
    check("rsp_zero", 64'(bus.rsp_zero), 64'(expz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gcnt;
    int gid[4];
    int gcyc[4];
    bit seen;
    logic [WIDTH-1:0] a, b;
    bit acc0, acc1;

    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_literal",
          64'({bus.req0_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data,
               bus.rsp_zero}), 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Single OR on requester 0: ready in the first IDLE cycle.
    run_op(0, 2'b00, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, w);
    check("first_idle_ready", 64'(w), 64'd0);

    // Zero-flag corners.
    run_op(0, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, w);
    run_op(1, 2'b10, 16'hAAAA, 16'h5555, 16'h0000, 1'b1, w);
    run_op(0, 2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b1, w);
    run_op(1, 2'b01, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, w);

    // Backpressure on requester 1 while requester 0 waits.
    @(posedge clk); #1;
    drive_req(1, 2'b11, 16'h1234, 16'h00FF);
    wait_ready(1, w);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.rsp1_ready = 1'b0;
    drive_req(0, 2'b00, 16'h0001, 16'h0010);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.rsp1_valid) seen = 1;
    end
    check("bp_rsp1_rise", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold", 64'({bus.rsp1_valid, bus.busy, bus.req0_ready, bus.rsp_data}),
            64'({1'b1, 1'b1, 1'b0, 16'h12CB}));
    end
    @(posedge clk); #1 bus.rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_exit_cycle", 64'({bus.rsp1_valid, bus.req0_ready}), 64'(2'b10));
    @(negedge clk);
    check("bp_req0_accept", 64'({bus.rsp1_valid, bus.req0_ready}), 64'(2'b01));
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_req0_rsp", 64'({bus.rsp0_valid, bus.rsp_data}), 64'({1'b1, 16'h0011}));

    // Reset during EXEC, then continuous contention from reset.
    @(posedge clk); #1;
    drive_req(1, 2'b10, 16'hF0F0, 16'hFF00);
    wait_ready(1, w);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    drive_req(0, 2'b00, 16'h0001, 16'h0002);
    drive_req(1, 2'b11, 16'h00FF, 16'h0F0F);
    #1 rst = 1'b1;
    #1;
    check("async_reset",
          64'({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid,
               bus.rsp_data, bus.rsp_zero}), 64'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    gcnt = 0;
    for (int k = 0; k < 40 && gcnt < 4; k++) begin
      @(negedge clk);
      if (k == 0) check("no_stale_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'd0);
      if (bus.rsp0_valid) check("cont_rsp0", 64'(bus.rsp_data), 64'(16'h0003));
      if (bus.rsp1_valid) check("cont_rsp1", 64'(bus.rsp_data), 64'(16'h0FF0));
      if (bus.req0_ready || bus.req1_ready) begin
        gid[gcnt]  = bus.req1_ready ? 1 : 0;
        gcyc[gcnt] = cycle;
        gcnt++;
      end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("cont_grant_count", 64'(gcnt), 64'd4);
    for (int i = 0; i < gcnt; i++) begin
      check("cont_grant_order", 64'(gid[i]), 64'(i % 2));
      if (i > 0) check("cont_grant_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    end
    repeat (4) @(negedge clk);

    // Opcode sweep with random operands, some forced to zero results.
    for (int r = 0; r < 2; r++) begin
      for (int op = 0; op < 4; op++) begin
        for (int rep = 0; rep < 3; rep++) begin
          a = WIDTH'($urandom);
          b = WIDTH'($urandom);
          if (rep == 1) b = a;
          if (rep == 2) b = ~a;
          run_op(r, 2'(op), a, b, ref_op(2'(op), a, b), ref_op(2'(op), a, b) == '0, w);
        end
      end
    end

    // Random traffic with random backpressure; the cycle model does the checking.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc0 = bus.req0_ready;
      acc1 = bus.req1_ready;
      @(posedge clk); #1;
      if (!bus.req0_valid || acc0) begin
        if ($urandom_range(0, 1) == 1)
          drive_req(0, 2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        else
          bus.req0_valid = 1'b0;
      end
      if (!bus.req1_valid || acc1) begin
        if ($urandom_range(0, 1) == 1)
          drive_req(1, 2'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        else
          bus.req1_valid = 1'b0;
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    acc0 = bus.req0_ready;
    acc1 = bus.req1_ready;
    @(posedge clk); #1;
    if (acc0) bus.req0_valid = 1'b0;
    if (acc1) bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 20 && (bus.req0_valid || bus.req1_valid); k++) begin
      @(negedge clk);
      acc0 = bus.req0_ready;
      acc1 = bus.req1_ready;
      @(posedge clk); #1;
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("drained_idle", 64'({bus.busy, bus.req0_valid, bus.req1_valid}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
